// File: rtl/dp_ram_fifo_ctrl_if.sv
// Bundles the FIFO user side and the dual-port RAM side of dp_ram_fifo_ctrl.
// slave = the controller, master = the logic that drives requests and models the RAM.
interface dp_ram_fifo_ctrl_if #(
  parameter int DW = 3,
  parameter int AW = 3
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;

  modport slave (
    input  wr_en, wr_data, rd_en, ram_dout_b,
    output rd_data, rd_valid, full, empty, almost_full, count, ovf, udf,
           ram_cs, ram_we, ram_addr_a, ram_data_a, ram_addr_b
  );

  modport master (
    output wr_en, wr_data, rd_en, ram_dout_b,
    input  rd_data, rd_valid, full, empty, almost_full, count, ovf, udf,
           ram_cs, ram_we, ram_addr_a, ram_data_a, ram_addr_b
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with a registered (1-cycle) read port.
// Writes land in the RAM on the accept edge; read data appears one cycle after an accepted read.
module dp_ram_fifo_ctrl #(
  parameter int DW       = 3,
  parameter int AW       = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dp_ram_fifo_ctrl_if.slave     bus
);
  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          full_w, empty_w;
  logic          wr_acc, rd_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en & ~full_w;
  assign rd_acc  = bus.rd_en & ~empty_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    ovf_d      = bus.wr_en & full_w;
    udf_d      = bus.rd_en & empty_w;
    // Pointers wrap naturally at DEPTH since they are exactly AW bits wide.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almost_full = (count_q >= AF_C);
  assign bus.count       = count_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = bus.ram_dout_b;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;
  assign bus.ram_cs      = wr_acc;
  assign bus.ram_we      = wr_acc;
  assign bus.ram_addr_a  = wr_ptr_q;
  assign bus.ram_data_a  = bus.wr_data;
  assign bus.ram_addr_b  = rd_ptr_q;
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Scoreboard bench for dp_ram_fifo_ctrl: a queue-based FIFO model predicts read data,
// flags and RAM strobes; a separate monitor compares read data whenever rd_valid is high.
module tb_dp_ram_fifo_ctrl;
  localparam int DW = 3;
  localparam int AW = 3;

  logic clk;
  logic rst_n;

  dp_ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  dp_ram_fifo_ctrl #(.DW(DW), .AW(AW), .AF_LEVEL(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural dual-port RAM: synchronous write on port A, registered read on port B.
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr_a] <= bus.ram_data_a;
    bus.ram_dout_b <= mem[bus.ram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] mq[$];     // model FIFO contents
  logic [DW-1:0] exp_q[$];  // expected read data, pushed on accepted reads
  int  wcnt, rcnt;
  bit  exp_ovf, exp_udf;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    wcnt = 0;
    rcnt = 0;
    exp_ovf = 0;
    exp_udf = 0;
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit re);
    bit wacc, racc;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(negedge clk);
    wacc = we && (mq.size() < 8);
    racc = re && (mq.size() > 0);
    chk("count", int'(bus.count), mq.size());
    chk("full", int'(bus.full), int'(mq.size() == 8));
    chk("empty", int'(bus.empty), int'(mq.size() == 0));
    chk("almost_full", int'(bus.almost_full), int'(mq.size() >= 6));
    chk("ram_cs", int'(bus.ram_cs), int'(wacc));
    chk("ram_we", int'(bus.ram_we), int'(wacc));
    chk("ovf", int'(bus.ovf), int'(exp_ovf));
    chk("udf", int'(bus.udf), int'(exp_udf));
    chk("ram_addr_b", int'(bus.ram_addr_b), rcnt % 8);
    if (wacc) begin
      chk("ram_addr_a", int'(bus.ram_addr_a), wcnt % 8);
      chk("ram_data_a", int'(bus.ram_data_a), int'(wd));
    end
    @(posedge clk);
    #1;
    exp_ovf = we && !wacc;
    exp_udf = re && !racc;
    if (racc) begin
      exp_q.push_back(mq.pop_front());
      rcnt++;
    end
    if (wacc) begin
      mq.push_back(wd);
      wcnt++;
    end
  endtask

  // Monitor: compares every presented read word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 1, 0);
      end else begin
        chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_ram_cs", int'(bus.ram_cs), 0);
    chk("rst_almost_full", int'(bus.almost_full), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 1..7,0, then overflow attempt.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(i + 1), 1'b0);
    cyc(1'b1, 3'd5, 1'b0);
    // Drain 8 words, then one read on empty.
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Preload 3, then 10 cycles of simultaneous traffic across the pointer wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Simultaneous requests at empty: only the write goes in.
    cyc(1'b1, 3'd6, 1'b1);
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'($urandom), 1'b0);

    // Mid-operation reset with count=5 and a read being requested.
    chk("pre_reset_count", int'(bus.count), 5);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_rd_valid", int'(bus.rd_valid), 0);
    chk("mid_rst_ram_cs", int'(bus.ram_cs), 0);
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rd_valid", int'(bus.rd_valid), 0);
    chk("post_rst_count", int'(bus.count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic, biased in phases toward filling and toward draining.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      cyc(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < (100 - wp)));
    end
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
